// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs buffered multi-cycle results.
// Optional statistics counters (stall_cnt, drop_cnt) are enabled by defining WB_ARB_STATS_EN.
module rf_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_we,
    input  logic [4:0]  p_wa,
    input  logic [31:0] p_wd,
    output logic        p_stall,
    input  logic        m_valid,
    input  logic [4:0]  m_wa,
    input  logic [31:0] m_wd,
    output logic        m_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        hz1,
    output logic        hz2
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

    logic [DEPTH-1:0] live;
    logic [4:0]       wa_mem [DEPTH];
    logic [31:0]      wd_mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [SW-1:0]    scnt;

    logic head_live;
    logic head_dead;
    logic forced;
    logic p_grant;
    logic h_grant;
    logic pop;
    logic push;

    // Handshake: a result transfers on a cycle where m_valid && m_ready; m_ready
    // comes from the registered count only, so a full buffer never accepts even
    // when it pops in the same cycle.
    always_comb begin
        head_live = (count != '0) && live[head];
        head_dead = (count != '0) && !live[head];
        forced    = head_live && (scnt == SMAX_C);
        m_ready   = !rst && (count < DEPTH_C);
        push      = m_valid && m_ready;
        p_stall   = !rst && forced;
        p_grant   = !rst && !forced && p_we && (p_wa != 5'd0);
        h_grant   = !rst && (forced || (!p_grant && head_live));
        pop       = h_grant || (!rst && head_dead);
    end

    always_comb begin
        rf_we = 1'b0;
        rf_wa = 5'd0;
        rf_wd = 32'd0;
        if (h_grant) begin
            rf_we = 1'b1;
            rf_wa = wa_mem[head];
            rf_wd = wd_mem[head];
        end else if (p_grant) begin
            rf_we = 1'b1;
            rf_wa = p_wa;
            rf_wd = p_wd;
        end
    end

    // Only live slots take part; freed and squashed slots always have live cleared.
    always_comb begin
        hz1 = 1'b0;
        hz2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (wa_mem[i] == ra1)) hz1 = 1'b1;
            if (live[i] && (wa_mem[i] == ra2)) hz2 = 1'b1;
        end
        if (rst || (ra1 == 5'd0)) hz1 = 1'b0;
        if (rst || (ra2 == 5'd0)) hz2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            scnt  <= '0;
        end else begin
            // A granted pipeline write is younger than any buffered result to the same register.
            for (int i = 0; i < DEPTH; i++) begin
                if (p_grant && live[i] && (wa_mem[i] == p_wa)) live[i] <= 1'b0;
            end
            if (pop) begin
                live[head] <= 1'b0;
                head       <= head + PW'(1);
            end
            if (push) begin
                live[tail] <= (m_wa != 5'd0);
                tail       <= tail + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (!head_live || h_grant) scnt <= '0;
            else if (scnt != SMAX_C)   scnt <= scnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wa_mem[tail] <= m_wa;
            wd_mem[tail] <= m_wd;
        end
    end

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            drop_cnt  <= 16'd0;
        end else begin
            if (p_stall) stall_cnt <= stall_cnt + 32'd1;
            if (head_dead && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios then random traffic, checked against
// a queue-based model of the buffer, starvation rule and WAW squash.
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_we = 1'b0;
    logic [4:0]  p_wa = 5'd0;
    logic [31:0] p_wd = 32'd0;
    logic        p_stall;
    logic        m_valid = 1'b0;
    logic [4:0]  m_wa = 5'd0;
    logic [31:0] m_wd = 32'd0;
    logic        m_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  ra1 = 5'd0;
    logic [4:0]  ra2 = 5'd0;
    logic        hz1;
    logic        hz2;
`ifdef WB_ARB_STATS_EN
    logic [31:0] stall_cnt;
    logic [15:0] drop_cnt;
`endif

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_wa(p_wa), .p_wd(p_wd), .p_stall(p_stall),
        .m_valid(m_valid), .m_wa(m_wa), .m_wd(m_wd), .m_ready(m_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .ra1(ra1), .ra2(ra2), .hz1(hz1), .hz2(hz2)
`ifdef WB_ARB_STATS_EN
        , .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model state
    typedef struct {
        bit          live;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;
    ent_t mq[$];
    int   starve = 0;
    int   m_stalls = 0;
    int   m_drops = 0;

    // scoreboard
    logic [36:0] exp_q[$];
    logic [3:0]  side_q[$];
    int total = 0;
    int bad = 0;

    // one clock of stimulus; the model predicts this cycle's outputs and then
    // advances to the state after the coming rising edge
    task automatic cycle(input logic r, input logic pwe, input logic [4:0] pwa,
                         input logic [31:0] pwd, input logic mv, input logic [4:0] mwa,
                         input logic [31:0] mwd, input logic [4:0] a1, input logic [4:0] a2,
                         output logic acc);
        bit hl, hd, fo, rdy, h1, h2, hg;
        @(posedge clk);
        #1;
        rst = r; p_we = pwe; p_wa = pwa; p_wd = pwd;
        m_valid = mv; m_wa = mwa; m_wd = mwd; ra1 = a1; ra2 = a2;
        acc = 1'b0;
        if (r) begin
            mq.delete();
            starve = 0;
            m_stalls = 0;
            m_drops = 0;
            side_q.push_back(4'b0000);
            return;
        end
        hl  = (mq.size() > 0) && mq[0].live;
        hd  = (mq.size() > 0) && !mq[0].live;
        fo  = hl && (starve == SMAX);
        rdy = mq.size() < DEPTH;
        h1  = 0;
        h2  = 0;
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].wa == a1 && a1 != 0) h1 = 1;
            if (mq[i].live && mq[i].wa == a2 && a2 != 0) h2 = 1;
        end
        side_q.push_back({fo, rdy, h1, h2});
        hg = 0;
        if (fo) begin
            exp_q.push_back({mq[0].wa, mq[0].wd});
            hg = 1;
        end else if (pwe && pwa != 0) begin
            exp_q.push_back({pwa, pwd});
            foreach (mq[i]) if (mq[i].live && mq[i].wa == pwa) mq[i].live = 0;
        end else if (hl) begin
            exp_q.push_back({mq[0].wa, mq[0].wd});
            hg = 1;
        end
        if (hg) void'(mq.pop_front());
        else if (hd) begin
            void'(mq.pop_front());
            if (m_drops < 65535) m_drops++;
        end
        if (hg || !hl) starve = 0;
        else if (starve < SMAX) starve++;
        if (fo) m_stalls++;
        if (mv && rdy) begin
            ent_t e;
            e.live = (mwa != 0);
            e.wa = mwa;
            e.wd = mwd;
            mq.push_back(e);
            acc = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    endtask

    // monitor: compares flags every driven cycle, and each presented write
    always @(negedge clk) begin
        logic [3:0]  fe;
        logic [36:0] we;
        if (side_q.size() > 0) begin
            fe = side_q.pop_front();
            total++;
            if ({p_stall, m_ready, hz1, hz2} !== fe) begin
                bad++;
                $display("FAIL flags t=%0t stall/ready/hz1/hz2 got=%b want=%b", $time,
                         {p_stall, m_ready, hz1, hz2}, fe);
            end
            if (rf_we === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write t=%0t got wa=%0d wd=%h want none", $time, rf_wa, rf_wd);
                end else begin
                    we = exp_q.pop_front();
                    if ({rf_wa, rf_wd} !== we) begin
                        bad++;
                        $display("FAIL write t=%0t got wa=%0d wd=%h want wa=%0d wd=%h", $time,
                                 rf_wa, rf_wd, we[36:32], we[31:0]);
                    end
                end
            end else if (exp_q.size() > 0) begin
                total++;
                bad++;
                we = exp_q.pop_front();
                $display("FAIL missing_write t=%0t got rf_we=%b want wa=%0d wd=%h", $time,
                         rf_we, we[36:32], we[31:0]);
            end
        end
    end

    initial begin
        logic a;
        logic        pend_v;
        logic [4:0]  pend_wa;
        logic [31:0] pend_wd;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, a);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, a);

        // pipeline only
        cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, a);

        // idle drain with hazard visible only while buffered
        cycle(0, 0, 0, 0, 1, 7, 32'h11, 7, 0, a);
        cycle(0, 0, 0, 0, 0, 0, 0, 7, 7, a);
        cycle(0, 0, 0, 0, 0, 0, 0, 7, 0, a);

        // starvation
        cycle(0, 1, 9, 32'h900, 1, 3, 32'h33, 0, 3, a);
        for (int i = 0; i < 7; i++) cycle(0, 1, 9, 32'h901 + i, 0, 0, 0, 3, 0, a);
        idle(2);

        // full buffer, third result held until accepted
        cycle(0, 1, 9, 32'h1, 1, 1, 32'hA1, 0, 0, a);
        cycle(0, 1, 9, 32'h2, 1, 2, 32'hA2, 0, 0, a);
        a = 0;
        for (int i = 0; i < 12 && !a; i++) cycle(0, 1, 9, 32'h10 + i, 1, 6, 32'hA6, 6, 2, a);
        idle(6);

        // WAW squash
        cycle(0, 1, 9, 32'h3, 1, 4, 32'hAA, 4, 0, a);
        cycle(0, 1, 4, 32'hBB, 0, 0, 0, 4, 4, a);
        cycle(0, 0, 0, 0, 0, 0, 0, 4, 4, a);
        idle(2);

        // x0 result never writes
        cycle(0, 0, 0, 0, 1, 0, 32'h55, 0, 0, a);
        idle(2);

        // reset mid-operation with two entries buffered and scnt at 3
        cycle(0, 1, 9, 32'h4, 1, 11, 32'hB1, 0, 0, a);
        cycle(0, 1, 9, 32'h5, 1, 12, 32'hB2, 11, 12, a);
        cycle(0, 1, 9, 32'h6, 0, 0, 0, 0, 0, a);
        cycle(0, 1, 9, 32'h7, 0, 0, 0, 0, 0, a);
        cycle(1, 0, 0, 0, 1, 13, 32'hB3, 11, 12, a);
        idle(6);

        // random traffic with a held multi-cycle handshake
        pend_v = 0;
        pend_wa = 0;
        pend_wd = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            if (!pend_v && $urandom_range(0, 2) == 0) begin
                pend_v = 1;
                pend_wa = 5'($urandom_range(0, 7));
                pend_wd = $urandom;
            end
            r = ($urandom_range(0, 99) == 0);
            cycle(r, ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
                  pend_v, pend_wa, pend_wd, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), a);
            if (a || r) pend_v = 0;
        end
        idle(12);

        @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0 || side_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", exp_q.size() + side_q.size());
        end
`ifdef WB_ARB_STATS_EN
        total++;
        if (stall_cnt !== 32'(m_stalls) || drop_cnt !== 16'(m_drops)) begin
            bad++;
            $display("FAIL stats got stall=%0d drop=%0d want stall=%0d drop=%0d",
                     stall_cnt, drop_cnt, m_stalls, m_drops);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (we/wa/wd, written on the falling clock edge) between two writers: the in-order pipeline writeback stage, and the multi-cycle unit (load-miss/mul-div), which returns out of order.
- Multi-cycle results wait in a small in-order buffer.
- Pipeline writeback has priority. A starvation counter stalls the pipeline to drain the buffer.
- Also reports hazards to decode for registers with a buffered pending write.

Parameters:
- DEPTH, 2: multi-cycle result buffer entries (power of 2, ≥2).
- STARVE_MAX, 4: consecutive denied cycles of a valid buffer head before the pipeline is forced to stall (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- p_we  in  1  pipeline writeback valid.
- p_wa  in  5  pipeline destination register.
- p_wd  in  32  pipeline write data.
- p_stall  out  1  freeze pipeline writeback; p_* held stable and ignored this cycle.
- m_valid  in  1  multi-cycle result valid.
- m_wa  in  5  multi-cycle destination register.
- m_wd  in  32  multi-cycle result data.
- m_ready  out  1  buffer can accept; transfer when m_valid && m_ready.
- rf_we  out  1  to register file write enable.
- rf_wa  out  5  to register file write address.
- rf_wd  out  32  to register file write data.
- ra1  in  5  decode source register 1.
- ra2  in  5  decode source register 2.
- hz1  out  1  ra1 != 0 and matches a live buffered entry.
- hz2  out  1  ra2 != 0 and matches a live buffered entry.

Behaviour:
- State:
  - Circular buffer of DEPTH entries {live, wa, wd}, with head/tail pointers and count (0..DEPTH).
  - Starvation counter scnt (0..STARVE_MAX).
- Reset:
  - count=0, pointers=0, scnt=0, all live=0.
  - While rst=1: rf_we=0, m_ready=0, p_stall=0, hz1=hz2=0.
- m_ready = (count < DEPTH), from registered count only; no push into a full buffer, even with a same-cycle pop.
- Push:
  - A new entry is written at tail with live = (m_wa != 0); tail and count advance.
  - It is visible for arbitration/hazard from the next cycle (no same-cycle bypass).
- Head states:
  - head_live = count>0 && live[head].
  - head_dead = count>0 && !live[head].
- Forced = head_live && scnt == STARVE_MAX. p_stall = forced (depends on registers only).
- Port select, in priority order:
  1. forced: head → rf; pop.
  2. p_we && p_wa != 0: pipeline → rf.
  3. head_live: head → rf; pop.
  4. Otherwise rf_we=0.
- head_dead entries pop in any cycle without using the port (p_we may write concurrently).
- p_we with p_wa==0: no write; port counts as free.
- Latency: the pipeline write is combinational to rf_* (same cycle); a buffered result is written no earlier than the cycle after push.
- WAW squash: when the pipeline is granted with p_wa = X, every live buffered entry with wa == X is cleared to live=0 (the younger pipeline write wins). This applies at the same clock edge as the write.
- scnt:
  - Set to 0 when the head is granted, or when !head_live.
  - Increments (saturating at STARVE_MAX) when head_live and not granted.
- Simultaneous push and pop: count unchanged; pointers both advance and wrap modulo DEPTH.
- hz1/hz2: combinational compare against all live entries.
- Reset mid-operation discards all buffered entries. No writes are issued for them.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- When defined, adds output stall_cnt [31:0]:
  - Counts cycles with p_stall=1; wraps at 2^32.
  - Reset to 0.
  - Also adds output drop_cnt [15:0]: counts squashed or x0 entries popped, saturating.
- Without it, these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Pipeline only: p_we=1, p_wa=5, p_wd=0xDEADBEEF, buffer empty → same cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; p_stall=0.
- Idle drain: push m_wa=7, m_wd=0x11 with p_we=0 → next cycle rf_we=1, rf_wa=7, rf_wd=0x11; count returns to 0; hz1=1 for ra1=7 only in the cycle the entry is buffered.
- Starvation: push m_wa=3 while p_we=1 (p_wa=9) continuously → head denied 4 cycles, 5th cycle p_stall=1 and rf_wa=3, then p_stall=0 and the pipeline resumes.
- Full: push 2 entries with p_we=1 held → m_ready=0; a third m_valid is not accepted until a pop; no entry lost or duplicated across pointer wrap.
- WAW squash: buffer holds wa=4 (wd=0xAA); pipeline writes p_wa=4, wd=0xBB → rf gets 0xBB; the entry later pops with rf_we=0; hz for ra=4 drops after the squash.
- Reset mid-operation: rst=1 with 2 entries buffered and scnt=3 → next cycle count=0, m_ready=0 during reset, no rf_we for discarded entries after reset releases.
